// File: rtl/uart_tx_serializer_if.sv
// FIFO read-side handshake between the TX serializer (master) and the CPU output FIFO (slave).
interface uart_tx_serializer_if;
  logic [7:0] FIFO_DO;
  logic       FIFO_FE;
  logic       RREQ;

  modport master (output RREQ, input FIFO_DO, input FIFO_FE);
  modport slave  (input RREQ, output FIFO_DO, output FIFO_FE);
endinterface

// File: rtl/uart_tx_serializer.sv
// Pops bytes from the CPU output FIFO and shifts them out LSB-first as UART frames
// (start, 8 data, optional parity, 1 or 2 stop bits) on a registered TX line.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  uart_tx_serializer_if.master        fifo,
  output logic                        TX,
  output logic                        BUSY,
  output logic                        TX_DONE
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PAR, STOP} state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          par_bit, par_bit_d;
  logic          stop_n, stop_n_d;
  logic          tx_d;
  logic          wrap;

  assign wrap = (baud == BAUD_LAST);
  assign BUSY = (state != IDLE);

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    idx_d     = idx;
    shift_d   = shift;
    par_bit_d = par_bit;
    stop_n_d  = stop_n;
    fifo.RREQ = 1'b0;
    TX_DONE   = 1'b0;

    if (state == START || state == DATA || state == PAR || state == STOP)
      baud_d = wrap ? '0 : baud + BW'(1);

    unique case (state)
      IDLE:  if (!fifo.FIFO_FE) state_d = REQ;
      REQ: begin
        fifo.RREQ = 1'b1;
        state_d   = LOAD;
      end
      // FIFO_DO was updated on the REQ edge, so it is stable here.
      LOAD: begin
        shift_d   = fifo.FIFO_DO;
        par_bit_d = (PARITY == 2) ? ~^fifo.FIFO_DO : ^fifo.FIFO_DO;
        baud_d    = '0;
        idx_d     = '0;
        stop_n_d  = 1'b0;
        state_d   = START;
      end
      START: if (wrap) begin
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: if (wrap) begin
        shift_d = {1'b0, shift[7:1]};
        idx_d   = idx + 3'd1;
        if (idx == 3'd7) state_d = (PARITY != 0) ? PAR : STOP;
      end
      PAR:   if (wrap) state_d = STOP;
      STOP: if (wrap) begin
        if (stop_n == STOP_LAST) begin
          TX_DONE  = 1'b1;
          stop_n_d = 1'b0;
          state_d  = IDLE;
        end else begin
          stop_n_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // TX is registered from the next state so the line changes exactly on state entry.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      baud    <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      stop_n  <= 1'b0;
      TX      <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      idx     <= idx_d;
      shift   <= shift_d;
      par_bit <= par_bit_d;
      stop_n  <= stop_n_d;
      TX      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: three serializer configs fed by a queue-backed FIFO model, frames checked bit-by-bit.
module tb_uart_tx_serializer;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_tx_serializer_if if0();
  uart_tx_serializer_if if1();
  uart_tx_serializer_if if2();

  logic [2:0] tx, busy, done, rreq_v;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK(clk), .RSTN(rstn), .fifo(if0), .TX(tx[0]), .BUSY(busy[0]), .TX_DONE(done[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u1 (
    .CLK(clk), .RSTN(rstn), .fifo(if1), .TX(tx[1]), .BUSY(busy[1]), .TX_DONE(done[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u2 (
    .CLK(clk), .RSTN(rstn), .fifo(if2), .TX(tx[2]), .BUSY(busy[2]), .TX_DONE(done[2]));

  // Only the selected instance sees the FIFO; the others see it empty.
  logic [1:0] sel = 2'd0;
  logic       fq_empty = 1'b1;
  logic       fe_hi = 1'b0;
  logic [7:0] fdo = 8'h00;
  byte unsigned fq[$];

  logic fe_s, tx_s, busy_s, done_s, rreq_s;
  assign fe_s = fq_empty | fe_hi;
  assign if0.FIFO_FE = (sel == 2'd0) ? fe_s : 1'b1;
  assign if1.FIFO_FE = (sel == 2'd1) ? fe_s : 1'b1;
  assign if2.FIFO_FE = (sel == 2'd2) ? fe_s : 1'b1;
  assign if0.FIFO_DO = fdo;
  assign if1.FIFO_DO = fdo;
  assign if2.FIFO_DO = fdo;
  assign rreq_v = {if2.RREQ, if1.RREQ, if0.RREQ};
  assign tx_s   = tx[sel];
  assign busy_s = busy[sel];
  assign done_s = done[sel];
  assign rreq_s = rreq_v[sel];

  int total = 0;
  int bad = 0;
  int rreq_cnt = 0;
  int gap, flen, base, b0, n, errs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fq_empty = 1'b0;
  endtask

  // FIFO model: a pop seen mid-REQ puts the byte on DO before the LOAD cycle.
  always @(negedge clk) begin
    if (rreq_s) begin
      rreq_cnt++;
      chk("rreq_while_empty", fe_s, 0);
      if (fq.size() > 0) fdo = fq.pop_front();
    end
    fq_empty = (fq.size() == 0);
  end

  // eb: expected TX level per bit time, bit k = k-th bit of the frame.
  task automatic frame(input string tag, input logic [11:0] eb, input int nbits,
                       output int g, output int fl);
    int err, dpos, nd;
    g = 0; fl = 0; err = 0; dpos = -1; nd = 0;
    while (tx_s !== 1'b0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (tx_s !== 1'b0) begin
      chk({tag, "_start_timeout"}, 0, 1);
      return;
    end
    for (int k = 0; k < nbits * CPB; k++) begin
      if (tx_s !== eb[k / CPB]) err++;
      if (busy_s !== 1'b1) err++;
      if (done_s === 1'b1) begin
        nd++;
        dpos = k;
      end
      @(negedge clk);
    end
    fl = dpos + 1;
    chk({tag, "_wave"}, err, 0);
    chk({tag, "_done_cnt"}, nd, 1);
    chk({tag, "_idle_after"}, {busy_s, tx_s, done_s}, 3'b010);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // reset held with data waiting
    rstn = 1'b0;
    push(8'h55);
    repeat (4) begin
      @(negedge clk);
      chk("rst_outputs", {tx_s, rreq_s, busy_s, done_s}, 4'b1000);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("rreq_after_release", rreq_s, 1);
    @(negedge clk);
    chk("rreq_one_cycle", rreq_s, 0);

    // 0x55 8N1
    frame("t2_55", 12'h2AA, 10, gap, flen);
    chk("t2_len", flen, 40);

    // 0x07 with even / odd parity, two stop bits
    sel = 2'd1;
    push(8'h07);
    frame("t3_even", 12'hE0E, 12, gap, flen);
    chk("t3_even_len", flen, 48);
    sel = 2'd2;
    push(8'h07);
    frame("t3_odd", 12'hC0E, 12, gap, flen);
    chk("t3_odd_len", flen, 48);

    // three queued bytes back to back
    sel = 2'd0;
    base = rreq_cnt;
    push(8'hA5); push(8'h00); push(8'hFF);
    frame("t4_a5", 12'h34A, 10, gap, flen);
    chk("t4_a5_len", flen, 40);
    frame("t4_00", 12'h200, 10, gap, flen);
    chk("t4_gap1", gap, 3);
    frame("t4_ff", 12'h3FE, 10, gap, flen);
    chk("t4_gap2", gap, 3);
    repeat (20) @(negedge clk);
    chk("t4_rreq_cnt", rreq_cnt - base, 3);

    // reset mid-frame in data bit 3 of 0xC3
    push(8'hC3);
    n = 0;
    while (tx_s !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start", tx_s, 0);
    repeat (18) @(negedge clk);
    chk("t5_bit3", {busy_s, tx_s}, 2'b10);
    base = rreq_cnt;
    #2 rstn = 1'b0;
    #1 chk("t5_async_tx", {tx_s, busy_s}, 2'b10);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    errs = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_s !== 1'b1 || busy_s !== 1'b0) errs++;
    end
    chk("t5_idle_after", errs, 0);
    chk("t5_no_rreq", rreq_cnt - base, 0);

    // FE toggling during a frame must not trigger a pop
    b0 = rreq_cnt;
    push(8'h3C);
    n = 0;
    while (rreq_cnt == b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    base = rreq_cnt;
    chk("t6_rreq_a", base - b0, 1);
    fork
      frame("t6_3c", 12'h278, 10, gap, flen);
      begin
        repeat (6) @(negedge clk);
        push(8'h81);
        repeat (5) @(negedge clk);
        fe_hi = 1'b1;
        repeat (7) @(negedge clk);
        fe_hi = 1'b0;
        repeat (6) @(negedge clk);
        fe_hi = 1'b1;
        repeat (4) @(negedge clk);
        fe_hi = 1'b0;
      end
    join
    chk("t6_len", flen, 40);
    chk("t6_no_rreq_mid", rreq_cnt - base, 0);
    frame("t6_81", 12'h302, 10, gap, flen);
    chk("t6_gap", gap, 3);
    chk("t6_rreq_b", rreq_cnt - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
